// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one synchronous imem read per cycle and
// buffers {pc, instr} pairs in a small FIFO towards decode.
module fetch_stage #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               branch_taken,
    output logic               fetch_stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               dbg_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {WARM = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic               inflight_q, drop_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic               pop, push;
    logic [CNT_W:0]     occupancy;

    // Handshake: decode takes the head on any cycle where out_valid and
    // out_ready are both high; the head advances at that rising edge.
    assign out_valid = (count_q != '0);
    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign pop       = out_valid & out_ready;

    // Credit check counts the in-flight read so its response always has a slot.
    assign occupancy   = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign imem_req    = (state_q == RUN) & ~branch_taken & (occupancy < (CNT_W+1)'(DEPTH));
    assign fetch_stall = ~imem_req;
    assign imem_addr   = pc_in;
    assign push        = inflight_q & ~drop_q & ~branch_taken;
    assign dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= WARM;
        else       state_q <= state_d;
    end

    // The single WARM cycle lines up with the PC holding 0 after reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WARM:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = WARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            pc_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            inflight_q <= imem_req;
            drop_q     <= branch_taken & inflight_q;
            if (imem_req) pc_q <= pc_in;
            if (branch_taken) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[wr_ptr_q]    <= pc_q;
                    instr_mem_q[wr_ptr_q] <= imem_rdata;
                    wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && count_q == CNT_W'(DEPTH)));
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: program-order model of the accepted stream
// plus literal cycle checks around reset, backpressure, flush and re-reset.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = 16'h0;
    logic        branch_taken = 1'b0;
    logic [15:0] br_target = 16'h0;
    logic        fetch_stall, imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_instr, out_pc;
    logic        dbg_state;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    fetch_stage #(.ADDR_W(16), .INSTR_W(16), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .pc_in(pc), .branch_taken(branch_taken),
        .fetch_stall(fetch_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .dbg_state(dbg_state)
    );

    // clock / environment: PC register and 1-cycle instruction memory
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset)              pc <= 16'h0;
        else if (branch_taken)  pc <= br_target;
        else if (!fetch_stall)  pc <= pc + 16'h1;
    end

    always @(posedge clk) begin
        if (imem_req === 1'b1) imem_rdata <= imem_addr ^ 16'hA5A5;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int start = n_acc;
        int i = 0;
        while (n_acc < start + n && i < budget) begin
            cyc();
            i++;
        end
        total++;
        if (n_acc < start + n) begin
            bad++;
            $display("FAIL %s: accepted %0d want %0d", name, n_acc - start, n);
        end
    endtask

    // Scoreboard: accepted instructions follow program order, restarting at
    // the branch target on a flush and at 0 after reset.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_q.push_back(16'h0);
        end else begin
            chk("stall_is_not_req", fetch_stall, !imem_req);
            chk("imem_addr", imem_addr, pc);
            if (branch_taken) chk("req_during_flush", imem_req, 0);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk("stream_pc", out_pc, e);
                chk("stream_instr", out_instr, e ^ 16'hA5A5);
                n_acc++;
                if (exp_q.size() == 0) exp_q.push_back(e + 16'h1);
            end
            if (branch_taken) begin
                exp_q.delete();
                exp_q.push_back(br_target);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values and first fetch timing
        cyc();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_stall", fetch_stall, 1);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_state", dbg_state, 0);
        cyc(); reset = 1'b0;
        @(negedge clk);
        chk("c1_req", imem_req, 0);
        chk("c1_stall", fetch_stall, 1);
        chk("c1_state", dbg_state, 0);
        cyc(); @(negedge clk);
        chk("c2_req", imem_req, 1);
        chk("c2_addr", imem_addr, 16'h0000);
        chk("c2_state", dbg_state, 1);
        cyc(); @(negedge clk);
        chk("c3_valid", out_valid, 0);
        cyc(); @(negedge clk);
        chk("c4_valid", out_valid, 1);
        chk("c4_pc", out_pc, 16'h0000);
        chk("c4_instr", out_instr, 16'hA5A5);
        for (int k = 1; k <= 2; k++) begin
            cyc(); @(negedge clk);
            chk("seq_valid", out_valid, 1);
            chk("seq_pc", out_pc, k);
        end

        // branch while pc_in = 5, target 0x0040
        cyc(); branch_taken = 1'b1; br_target = 16'h0040;
        @(negedge clk);
        chk("br_pc_in", pc, 16'h0005);
        chk("br_head_pc", out_pc, 16'h0003);
        chk("br_head_valid", out_valid, 1);
        chk("br_stall", fetch_stall, 1);
        cyc(); branch_taken = 1'b0;
        @(negedge clk);
        chk("br_t1_valid", out_valid, 0);
        chk("br_t1_req", imem_req, 1);
        cyc(); @(negedge clk);
        chk("br_t2_valid", out_valid, 0);
        cyc(); @(negedge clk);
        chk("br_t3_valid", out_valid, 1);
        chk("br_t3_pc", out_pc, 16'h0040);
        chk("br_t3_instr", out_instr, 16'hA5E5);

        // five cycles of backpressure mid-stream
        repeat (3) cyc();
        out_ready = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("bp_valid", out_valid, 1);
        chk("bp_stall", fetch_stall, 1);
        chk("bp_req", imem_req, 0);
        cyc(); out_ready = 1'b1;
        wait_acc(6, 30, "bp_resume");

        // flush with the FIFO full and decode stalled
        cyc(); out_ready = 1'b0;
        repeat (3) cyc();
        branch_taken = 1'b1; br_target = 16'h0100;
        @(negedge clk);
        chk("full_stall", fetch_stall, 1);
        cyc(); branch_taken = 1'b0;
        @(negedge clk);
        chk("full_flush_valid", out_valid, 0);
        cyc(); out_ready = 1'b1;
        wait_acc(3, 20, "full_flush_resume");

        // flush while a read is in flight and decode stalls the same cycle
        repeat (4) cyc();
        out_ready = 1'b0; branch_taken = 1'b1; br_target = 16'h0200;
        cyc(); branch_taken = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("inflight_flush_valid", out_valid, 0);
        wait_acc(3, 20, "inflight_flush_resume");

        // reset mid-stream with out_ready toggling
        for (int i = 0; i < 6; i++) begin
            cyc(); out_ready = i[0];
        end
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rr_valid", out_valid, 0);
        chk("rr_req", imem_req, 0);
        cyc(); @(negedge clk);
        chk("rr_req2", imem_req, 1);
        chk("rr_addr", imem_addr, 16'h0000);
        wait_acc(4, 20, "rr_resume");

        // random decode backpressure, no branches, fresh start at pc 0
        cyc(); reset = 1'b1;
        cyc(); cyc(); reset = 1'b0;
        begin
            int start;
            start = n_acc;
            for (int i = 0; i < 1000; i++) begin
                out_ready = ($urandom_range(0, 1) == 1);
                cyc();
            end
            chk("rand_progress", (n_acc - start) >= 300, 1);
        end
        out_ready = 1'b1;
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
